// File: rtl/pipeline_run_ctrl.sv
// Run controller for the 5-stage pipeline core: sequences the core reset,
// counts run statistics and latches the end-of-test verdict. A verdict comes
// from a store to the tohost address or from the cycle budget running out.
module pipeline_run_ctrl #(
    parameter int              XLEN        = 32,
    parameter int              CNT_W       = 32,
    parameter int              RST_CYCLES  = 2,
    parameter int              MAX_CYCLES  = 1000,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_0FFC
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             core_rst_o,
    input  logic             retire_valid_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             dmem_we_i,
    input  logic [XLEN-1:0]  dmem_addr_i,
    input  logic [XLEN-1:0]  dmem_wdata_i,
    output logic             running_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic [XLEN-1:0]  exit_code_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instret_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int               HOLD_W    = $clog2(RST_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LAST_RUN  = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e            state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              core_rst_q;
    logic              running_q;
    logic              done_q;
    logic              pass_q;
    logic              fail_q;
    logic              timeout_q;
    logic [XLEN-1:0]   exit_code_q;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic [CNT_W-1:0]  instret_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic              tohost_hit_d;
    logic              budget_end_d;
    logic [CNT_W-1:0]  cycle_cnt_d;
    logic [CNT_W-1:0]  instret_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_d;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             en);
        return (en && (value != '1)) ? value + 1'b1 : value;
    endfunction

    // Next counter values and end-of-run conditions; used only in RUN.
    always_comb begin
        tohost_hit_d  = dmem_we_i && (dmem_addr_i == TOHOST_ADDR) && (dmem_wdata_i != '0);
        budget_end_d  = (cycle_cnt_q == LAST_RUN);
        cycle_cnt_d   = sat_inc(cycle_cnt_q, 1'b1);
        instret_cnt_d = sat_inc(instret_cnt_q, retire_valid_i);
        stall_cnt_d   = sat_inc(stall_cnt_q, stall_i);
        flush_cnt_d   = sat_inc(flush_cnt_q, flush_i);
    end

    // Run-control state machine with all outputs registered.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            core_rst_q    <= 1'b1;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            exit_code_q   <= '0;
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    hold_cnt_q <= hold_cnt_q + 1'b1;
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q    <= ST_RUN;
                        core_rst_q <= 1'b0;
                        running_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // The terminating cycle is itself counted.
                    cycle_cnt_q   <= cycle_cnt_d;
                    instret_cnt_q <= instret_cnt_d;
                    stall_cnt_q   <= stall_cnt_d;
                    flush_cnt_q   <= flush_cnt_d;
                    if (tohost_hit_d) begin
                        // A tohost store wins over a coincident budget expiry.
                        state_q     <= ST_DONE;
                        core_rst_q  <= 1'b1;
                        running_q   <= 1'b0;
                        done_q      <= 1'b1;
                        exit_code_q <= {1'b0, dmem_wdata_i[XLEN-1:1]};
                        pass_q      <= (dmem_wdata_i == XLEN'(1));
                        fail_q      <= (dmem_wdata_i != XLEN'(1));
                    end else if (budget_end_d) begin
                        state_q     <= ST_DONE;
                        core_rst_q  <= 1'b1;
                        running_q   <= 1'b0;
                        done_q      <= 1'b1;
                        timeout_q   <= 1'b1;
                        exit_code_q <= '0;
                    end
                end
                ST_DONE: begin
                    // Core frozen; counters and verdict hold until rst.
                end
                default: begin
                    state_q    <= ST_HOLD;
                    hold_cnt_q <= '0;
                    core_rst_q <= 1'b1;
                    running_q  <= 1'b0;
                end
            endcase
        end
    end

    assign core_rst_o    = core_rst_q;
    assign running_o     = running_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign fail_o        = fail_q;
    assign timeout_o     = timeout_q;
    assign exit_code_o   = exit_code_q;
    assign cycle_cnt_o   = cycle_cnt_q;
    assign instret_cnt_o = instret_cnt_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: doc/pipeline_run_ctrl.md
Name: pipeline_run_ctrl

Overview:
- Parametrised run controller for the 5-stage hazard pipeline; sits between the global clock/reset and the core.
- Sequences the core reset and counts cycles, retired instructions, hazard stalls and flushes.
- Detects program completion from a store to the TOHOST address, or from a cycle-budget timeout, then freezes the core and latches a pass/fail/timeout verdict.
- Replaces fixed-delay run-then-finish control with an explicit, self-reporting state machine.

Parameters:
XLEN, 32, data/address width of the monitored store bus
CNT_W, 32, width of every performance counter
RST_CYCLES, 2, cycles core_rst stays high after rst deasserts (legal range >=1)
MAX_CYCLES, 1000, RUN-cycle budget before timeout (legal range >=1, must fit CNT_W)
TOHOST_ADDR, 32'h0000_0FFC, store address that signals end of test

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
core_rst  out  1  registered reset driven to the pipeline core
retire_valid  in  1  one instruction retired (WB) this cycle
stall  in  1  hazard-unit stall asserted this cycle
flush  in  1  branch/jump flush asserted this cycle
dmem_we  in  1  data-memory write enable
dmem_addr  in  XLEN  data-memory address
dmem_wdata  in  XLEN  data-memory write data
running  out  1  state==RUN
done  out  1  sticky, run finished
pass  out  1  sticky, tohost value==1
fail  out  1  sticky, tohost value nonzero and !=1
timeout  out  1  sticky, budget exhausted
exit_code  out  XLEN  dmem_wdata>>1 of terminating store, zero-extended
cycle_cnt  out  CNT_W  RUN cycles elapsed
instret_cnt  out  CNT_W  retired instructions
stall_cnt  out  CNT_W  stall cycles
flush_cnt  out  CNT_W  flush cycles

Behaviour:
- Reset (rst=1 at edge): state=HOLD, hold counter=0, core_rst=1, done/pass/fail/timeout/running=0, exit_code=0, all counters=0. Reset in any state, including mid-RUN or DONE, returns to this state on that edge.
- HOLD: hold counter increments each edge with rst=0. On the edge where it reaches RST_CYCLES, go to RUN and clear core_rst. core_rst is low for the first time in the cycle after the RST_CYCLES-th low-rst cycle.
- RUN: each edge increments cycle_cnt by 1.
  - instret_cnt increments when retire_valid=1.
  - stall_cnt increments when stall=1.
  - flush_cnt increments when flush=1.
  - Inputs are sampled only in RUN; ignored in HOLD and DONE.
- Tohost detect, evaluated in RUN:
  - Trigger: dmem_we=1, dmem_addr==TOHOST_ADDR, dmem_wdata!=0.
  - At that edge: go to DONE, latch exit_code=dmem_wdata>>1, set pass if dmem_wdata==1, else set fail.
  - Counters still update on that edge, so the terminating store's cycle is counted.
  - dmem_wdata==0, or any other address: no effect.
- Timeout: in RUN, if cycle_cnt==MAX_CYCLES-1 at an edge with no tohost trigger, cycle_cnt becomes MAX_CYCLES and state becomes DONE with timeout=1, exit_code=0.
- Simultaneous tohost trigger and timeout edge: tohost wins (pass/fail set, timeout=0, cycle_cnt=MAX_CYCLES).
- DONE: core_rst=1 (core frozen), running=0, done=1. All counters and flags hold until rst; exactly one of pass/fail/timeout is 1.
- Counters saturate at all-ones and never wrap.
- Output latency: all outputs are registered; flags appear the cycle after the triggering edge's inputs.
- Exactly one of HOLD/RUN/DONE at all times; no unreachable states.

Test Plan:
- rst high 3 cycles then low, RST_CYCLES=2 -> core_rst=1 for exactly 2 cycles after rst falls, then 0; running=1; cycle_cnt=1 one edge later.
- RUN, retire_valid pulsed 10 of 15 cycles, stall 3, flush 2, then store wdata=1 to 0x0FFC -> done=1, pass=1, exit_code=0, instret_cnt=10 (or 11 if the store cycle also retires), stall_cnt=3, flush_cnt=2, core_rst=1.
- Store wdata=0x0000_0007 to 0x0FFC -> fail=1, pass=0, exit_code=3; store wdata=0 to 0x0FFC and wdata=1 to 0x0FF8 earlier -> no effect.
- MAX_CYCLES=64, no tohost -> timeout=1, done=1 with cycle_cnt=64; later inputs leave all counters unchanged.
- MAX_CYCLES=64, tohost wdata=1 on the 64th RUN cycle -> pass=1, timeout=0, cycle_cnt=64.
- rst asserted mid-RUN at cycle 20, and again in DONE -> next edge all outputs return to reset values (core_rst=1, counters=0, flags=0), HOLD sequence restarts.
